// File: rtl/xor_stream_unit.sv
// xor_stream_unit: streaming WIDTH-bit XOR unit with valid/ready on both sides
// and one registered output stage.
//   mode 00/11 : conditional invert
//   mode 01    : conditional XOR with the loadable key
//   mode 10    : running XOR checksum over BLOCK_LEN-word blocks
// Optional feature macro: XOR_UNIT_PARITY_EN adds out_parity = ^out_data.
//
// Handshake: a word transfers on any rising edge where valid && ready are both
// high. The sender keeps valid and its data steady until that edge. The unit
// raises in_ready whenever its output register is empty or is being drained
// this cycle. While out_valid && !out_ready, out_data and out_last stay frozen.
module xor_stream_unit #(
    parameter int WIDTH     = 8,
    parameter int BLOCK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             key_load,
    input  logic [WIDTH-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
`ifdef XOR_UNIT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam int CW = $clog2(BLOCK_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_LEN - 1);

    typedef enum logic {
        PASS  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [1:0]       mode_q;

    logic             accept;
    logic [1:0]       mode_norm;
    logic [1:0]       eff_mode;
    logic [WIDTH-1:0] contrib;
    logic             last_word;
    logic             produce;
    logic [WIDTH-1:0] result;
    logic             result_last;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    // Encoding 11 behaves exactly like invert and is stored as such.
    assign mode_norm = (mode == 2'b11) ? 2'b00 : mode;
    // A block in progress keeps the mode captured on its first word.
    assign eff_mode  = (state == PASS) ? mode_norm : mode_q;
    assign contrib   = en ? in_data : '0;
    assign last_word = (count == LAST_IDX);

    // Result selection and next FSM state for the word currently offered.
    always_comb begin
        produce     = 1'b1;
        result      = en ? ~in_data : in_data;
        result_last = 1'b0;
        state_next  = state;
        case (eff_mode)
            2'b01: begin
                result = en ? (in_data ^ key) : in_data;
            end
            2'b10: begin
                produce     = last_word;
                result      = acc ^ contrib;
                result_last = 1'b1;
            end
            default: begin
            end
        endcase
        if (accept) begin
            if (eff_mode == 2'b10 && !last_word) begin
                state_next = ACCUM;
            end else begin
                state_next = PASS;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    // Output register: loads on accept, empties when drained with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= produce;
            if (produce) begin
                out_data <= result;
                out_last <= result_last;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef XOR_UNIT_PARITY_EN
    // Parity travels with out_data and freezes with it under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else if (accept && produce) begin
            out_parity <= ^result;
        end
    end
`endif

    // Checksum accumulator and word counter; cleared when a block closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (accept && eff_mode == 2'b10) begin
            if (last_word) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= acc ^ contrib;
                count <= count + CW'(1);
            end
        end
    end

    // Mode capture: every word outside a block, only the first word of a block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 2'b00;
        end else if (accept && state == PASS) begin
            mode_q <= mode_norm;
        end
    end

    // Key register; a word accepted alongside key_load still sees the old key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key <= '0;
        end else if (key_load) begin
            key <= key_in;
        end
    end

endmodule

// File: tb/tb_xor_stream_unit.sv
// Directed self-checking bench for xor_stream_unit (WIDTH=8, BLOCK_LEN=4).
module tb_xor_stream_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       en;
    logic [1:0] mode;
    logic       key_load;
    logic [7:0] key_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
`ifdef XOR_UNIT_PARITY_EN
    logic       out_parity;
`endif

    int checks;
    int errors;
    int hs_count;
    int h0;

    xor_stream_unit #(
        .WIDTH    (8),
        .BLOCK_LEN(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .en       (en),
        .mode     (mode),
        .key_load (key_load),
        .key_in   (key_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
`ifdef XOR_UNIT_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    // Clock and output handshake counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_count <= 0;
        end else if (out_valid && out_ready) begin
            hs_count <= hs_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one word and returns #1 after the edge that accepted it.
    task automatic send(input logic [7:0] d, input logic e, input logic [1:0] m,
                        input logic kl, input logic [7:0] k);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        en       = e;
        mode     = m;
        key_load = kl;
        key_in   = k;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        key_load = 1'b0;
        check("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic l);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        en        = 1'b0;
        mode      = 2'b00;
        key_load  = 1'b0;
        key_in    = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Test 1: conditional invert
        send(8'hFF, 1'b1, 2'b00, 1'b0, 8'h00);
        expect_out("t1_w0", 8'h00, 1'b0);
`ifdef XOR_UNIT_PARITY_EN
        check("t1_par0", {31'd0, out_parity}, 32'd0);
`endif
        send(8'h9D, 1'b0, 2'b00, 1'b0, 8'h00);
        expect_out("t1_w1", 8'h9D, 1'b0);
`ifdef XOR_UNIT_PARITY_EN
        check("t1_par1", {31'd0, out_parity}, 32'd1);
`endif
        send(8'hC6, 1'b1, 2'b00, 1'b0, 8'h00);
        expect_out("t1_w2", 8'h39, 1'b0);
`ifdef XOR_UNIT_PARITY_EN
        check("t1_par2", {31'd0, out_parity}, 32'd0);
`endif
        send(8'hF0, 1'b1, 2'b11, 1'b0, 8'h00);
        expect_out("t1_w3", 8'h0F, 1'b0);
`ifdef XOR_UNIT_PARITY_EN
        check("t1_par3", {31'd0, out_parity}, 32'd0);
`endif

        // Test 2: key load, then same-cycle load uses the old key
        key_load = 1'b1;
        key_in   = 8'hA5;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        send(8'hF0, 1'b1, 2'b01, 1'b0, 8'h00);
        expect_out("t2_key", 8'h55, 1'b0);
        send(8'h0F, 1'b1, 2'b01, 1'b1, 8'h3C);
        expect_out("t2_oldkey", 8'hAA, 1'b0);
        send(8'h00, 1'b1, 2'b01, 1'b0, 8'h00);
        expect_out("t2_newkey", 8'h3C, 1'b0);
        send(8'h5A, 1'b0, 2'b01, 1'b0, 8'h00);
        expect_out("t2_en0", 8'h5A, 1'b0);

        // Test 3: checksum blocks
        send(8'h01, 1'b1, 2'b10, 1'b0, 8'h00);
        check("t3_nov1", {31'd0, out_valid}, 32'd0);
        send(8'h02, 1'b1, 2'b10, 1'b1, 8'h77);
        check("t3_nov2", {31'd0, out_valid}, 32'd0);
        send(8'h04, 1'b1, 2'b10, 1'b0, 8'h00);
        check("t3_nov3", {31'd0, out_valid}, 32'd0);
        send(8'h08, 1'b1, 2'b10, 1'b0, 8'h00);
        expect_out("t3_blk1", 8'h0F, 1'b1);
        send(8'h10, 1'b1, 2'b10, 1'b0, 8'h00);
        check("t3_b2_nov1", {31'd0, out_valid}, 32'd0);
        send(8'h00, 1'b0, 2'b10, 1'b0, 8'h00);
        send(8'hFF, 1'b1, 2'b10, 1'b0, 8'h00);
        check("t3_b2_nov3", {31'd0, out_valid}, 32'd0);
        send(8'hFF, 1'b1, 2'b10, 1'b0, 8'h00);
        expect_out("t3_blk2", 8'h10, 1'b1);

        // Test 4: backpressure holds the output, release hands off exactly once
        send(8'h12, 1'b0, 2'b00, 1'b0, 8'h00);
        expect_out("t4_first", 8'h12, 1'b0);
        out_ready = 1'b0;
        #1;
        h0       = hs_count;
        in_valid = 1'b1;
        in_data  = 8'h34;
        en       = 1'b1;
        mode     = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t4_hold_data", {24'd0, out_data}, 32'h12);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("t4_in_ready_high", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_out("t4_next", 8'hCB, 1'b0);
        check("t4_hs1", hs_count, h0 + 1);
        @(posedge clk);
        #1;
        check("t4_no_dup", {31'd0, out_valid}, 32'd0);
        check("t4_hs2", hs_count, h0 + 2);

        // Test 5: asynchronous reset mid-block
        send(8'h11, 1'b1, 2'b10, 1'b0, 8'h00);
        send(8'h22, 1'b1, 2'b10, 1'b0, 8'h00);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_data", {24'd0, out_data}, 32'd0);
        check("t5_rst_last", {31'd0, out_last}, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h10, 1'b1, 2'b10, 1'b0, 8'h00);
        send(8'h20, 1'b1, 2'b10, 1'b0, 8'h00);
        send(8'h40, 1'b1, 2'b10, 1'b0, 8'h00);
        check("t5_nov3", {31'd0, out_valid}, 32'd0);
        send(8'h80, 1'b1, 2'b10, 1'b0, 8'h00);
        expect_out("t5_blk", 8'hF0, 1'b1);

        // Test 6: mode change mid-block is ignored until the block closes
        send(8'h01, 1'b1, 2'b10, 1'b0, 8'h00);
        send(8'h02, 1'b1, 2'b10, 1'b0, 8'h00);
        send(8'h04, 1'b1, 2'b00, 1'b0, 8'h00);
        check("t6_nov3", {31'd0, out_valid}, 32'd0);
        send(8'h08, 1'b1, 2'b00, 1'b0, 8'h00);
        expect_out("t6_blk", 8'h0F, 1'b1);
        send(8'h55, 1'b1, 2'b00, 1'b0, 8'h00);
        expect_out("t6_inv", 8'hAA, 1'b0);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
